// File: rtl/inhibit_tt_sequencer.sv
// inhibit_tt_sequencer: sweeps the four input vectors of an inhibit gate (in1 & ~in2), samples its output
// after each dwell and reports err_cnt/pass/done. Optional macro INHIBIT_TT_FAILMASK_EN enables fail_mask.
// Revision: 1.0 - initial release
`default_nettype none

module inhibit_tt_sequencer #(
  parameter int DWELL = 50
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       inh_obs,
  output logic       in1,
  output logic       in2,
  output logic [1:0] vec_idx,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_cnt,
  output logic [3:0] fail_mask
);

  localparam int CW = $clog2(DWELL);
  localparam logic [CW-1:0] LAST = CW'(DWELL - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, APPLY = 2'd1, DONE = 2'd2} state_t;

  state_t        state, state_nx;
  logic [1:0]    vec_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [2:0]    err_nx;
  logic          sample;
  logic          mismatch;

  assign sample   = (state == APPLY) && (cnt == LAST);
  assign mismatch = inh_obs != (vec_idx[1] & ~vec_idx[0]);
  assign busy     = (state == APPLY);
  assign done     = (state == DONE);

  always_comb begin
    state_nx = state;
    vec_nx   = vec_idx;
    cnt_nx   = cnt;
    err_nx   = err_cnt;
    case (state)
      IDLE, DONE: begin
        vec_nx = 2'd0;
        cnt_nx = '0;
        if (start) begin
          state_nx = APPLY;
          err_nx   = 3'd0;
        end
      end
      APPLY: begin
        if (sample) begin
          cnt_nx = '0;
          if (mismatch) err_nx = err_cnt + 3'd1;
          if (vec_idx == 2'd3) begin
            state_nx = DONE;
            vec_nx   = 2'd0;
          end else begin
            vec_nx = vec_idx + 2'd1;
          end
        end else begin
          cnt_nx = cnt + CW'(1);
        end
      end
      default: begin
        state_nx = IDLE;
        vec_nx   = 2'd0;
        cnt_nx   = '0;
      end
    endcase
  end

  // Gate drives and pass are registered from next-state so they are glitch-free at the pins.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      vec_idx <= 2'd0;
      cnt     <= '0;
      err_cnt <= 3'd0;
      in1     <= 1'b0;
      in2     <= 1'b0;
      pass    <= 1'b0;
    end else begin
      state   <= state_nx;
      vec_idx <= vec_nx;
      cnt     <= cnt_nx;
      err_cnt <= err_nx;
      in1     <= (state_nx == APPLY) & vec_nx[1];
      in2     <= (state_nx == APPLY) & vec_nx[0];
      pass    <= (state_nx == DONE) && (err_nx == 3'd0);
    end
  end

`ifdef INHIBIT_TT_FAILMASK_EN
  logic [3:0] mask_r, mask_nx;

  always_comb begin
    mask_nx = mask_r;
    if ((state != APPLY) && start) mask_nx = 4'b0000;
    else if (sample && mismatch) mask_nx[vec_idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) mask_r <= 4'b0000;
    else     mask_r <= mask_nx;
  end

  assign fail_mask = mask_r;
`else
  assign fail_mask = 4'b0000;
`endif

endmodule

`default_nettype wire

// File: tb/tb_inhibit_tt_sequencer.sv
// Scoreboard bench for inhibit_tt_sequencer (DWELL = 4) with a selectable gate model on inh_obs.
// Revision: 1.0 - initial release
`default_nettype none

module tb_inhibit_tt_sequencer;

  localparam int DWELL = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       inh_obs;
  logic       in1, in2, busy, done, pass;
  logic [1:0] vec_idx;
  logic [2:0] err_cnt;
  logic [3:0] fail_mask;

  inhibit_tt_sequencer #(.DWELL(DWELL)) dut (
    .clk(clk), .rst(rst), .start(start), .inh_obs(inh_obs),
    .in1(in1), .in2(in2), .vec_idx(vec_idx), .busy(busy), .done(done),
    .pass(pass), .err_cnt(err_cnt), .fail_mask(fail_mask)
  );

  always #5 clk = ~clk;

  // 0: correct gate, 1: stuck at 1, 2: stuck at 0
  int mode = 0;
  assign inh_obs = (mode == 0) ? (in1 & ~in2) : (mode == 1);

  typedef struct {
    int         done_cyc;
    logic [2:0] err;
    logic       pass;
    logic [3:0] mask;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   e0       = 0;
  bit   tracking = 1'b0;
  logic prev_done = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [3:0] exp_mask(input logic [3:0] m);
`ifdef INHIBIT_TT_FAILMASK_EN
    return m;
`else
    return 4'b0000;
`endif
  endfunction

  task automatic sweep_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    e0       = cyc;
    tracking = 1'b1;
    start    = 1'b0;
  endtask

  task automatic push_exp(input logic [2:0] err, input logic [3:0] mask);
    exp_t e;
    e.done_cyc = e0 + 4 * DWELL;
    e.err      = err;
    e.pass     = (err == 3'd0);
    e.mask     = exp_mask(mask);
    q.push_back(e);
  endtask

  task automatic wait_done();
    bit seen = 1'b0;
    for (int i = 0; i < 10 * DWELL && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    if (!seen) check("done_timeout", 0, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in1"}, int'(in1), 0);
    check({tag, "_in2"}, int'(in2), 0);
    check({tag, "_vec_idx"}, int'(vec_idx), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_done"}, int'(done), 0);
    check({tag, "_pass"}, int'(pass), 0);
    check({tag, "_err_cnt"}, int'(err_cnt), 0);
    check({tag, "_fail_mask"}, int'(fail_mask), 0);
  endtask

  // Monitor: vector sequence while busy, and final results whenever done rises.
  always @(negedge clk) begin
    if (!rst && busy && tracking) begin
      int k;
      k = (cyc - e0) / DWELL;
      check("vec_idx", int'(vec_idx), k);
      check("in1", int'(in1), k[1]);
      check("in2", int'(in2), k[0]);
    end
    if (done && !prev_done) begin
      if (q.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("done_cycle", cyc, e.done_cyc);
        check("err_cnt", int'(err_cnt), int'(e.err));
        check("pass", int'(pass), int'(e.pass));
        check("fail_mask", int'(fail_mask), int'(e.mask));
        check("busy_at_done", int'(busy), 0);
        check("in_idle_at_done", int'({in1, in2, vec_idx}), 0);
      end
    end
    prev_done = done;
  end

  initial begin
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b0;

    // Correct gate: clean sweep
    mode = 0;
    sweep_start();
    check("busy_after_e0", int'(busy), 1);
    check("done_after_e0", int'(done), 0);
    push_exp(3'd0, 4'b0000);
    wait_done();

    // Stuck at 1: vectors 0, 1, 3 mismatch
    mode = 1;
    sweep_start();
    push_exp(3'd3, 4'b1011);
    wait_done();

    // Stuck at 0: only vector 2 mismatches
    mode = 2;
    sweep_start();
    push_exp(3'd1, 4'b0100);
    wait_done();

    // Start re-pulsed during vector 2 is ignored
    mode = 0;
    sweep_start();
    push_exp(3'd0, 4'b0000);
    repeat (9) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done();

    // Reset asserted at E0+6
    mode = 0;
    sweep_start();
    repeat (6) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    tracking = 1'b0;
    check_reset_outputs("midreset");
    @(negedge clk);
    rst = 1'b0;
    sweep_start();
    push_exp(3'd0, 4'b0000);
    wait_done();

    // Leave DONE with err_cnt = 3, then restart with a correct gate
    mode = 1;
    sweep_start();
    push_exp(3'd3, 4'b1011);
    wait_done();
    mode = 0;
    sweep_start();
    check("restart_err_cleared", int'(err_cnt), 0);
    check("restart_done_low", int'(done), 0);
    check("restart_mask_cleared", int'(fail_mask), 0);
    push_exp(3'd0, 4'b0000);
    wait_done();

    repeat (4) @(negedge clk);
    check("scoreboard_empty", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
